// File: rtl/branch_fwd_hazard_unit.sv
// ID-stage branch operand forwarding and hazard unit.
// Resolves BEQ/BNE source operands against the EX, MEM and WB destinations.
// Raises load-use and EX-dependency stalls, and flushes IF/ID on a taken branch.
// Keeps a consecutive-stall watchdog and saturating stall/forward counters.
module branch_fwd_hazard_unit #(
  parameter int AW        = 5,
  parameter int CNT_W     = 16,
  parameter int EX_FWD    = 1,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_branch,
  input  logic             id_taken,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    ex_rd,
  input  logic             mem_regwrite,
  input  logic             mem_memread,
  input  logic [AW-1:0]    mem_rd,
  input  logic             wb_regwrite,
  input  logic [AW-1:0]    wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             if_flush,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] fwd_cnt
);

  localparam int RW = $clog2(MAX_STALL + 1);
  localparam logic [RW-1:0] MAX_RL = RW'(MAX_STALL);
  localparam logic EX_NO_FWD = (EX_FWD == 0);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  logic [2:0]       infoA;
  logic [2:0]       infoB;
  logic             needStall;
  logic             fwdEvent;
  logic             hazardErr_q, hazardErr_d;
  logic [RW-1:0]    runLen_q, runLen_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] fwdCnt_q, fwdCnt_d;

  // Returns {stall need, operand select}; the youngest producer (EX) wins,
  // and register 0 never matches because it is hardwired to zero.
  function automatic logic [2:0] resolveOperand(input logic [AW-1:0] src);
    logic       valid;
    logic [2:0] r;
    valid = id_branch && (src != '0);
    r     = {1'b0, SEL_RF};
    if (valid && ex_regwrite && (ex_rd == src)) begin
      r = {ex_memread | EX_NO_FWD, SEL_EX};
    end else if (valid && mem_regwrite && (mem_rd == src)) begin
      r = {mem_memread, SEL_MEM};
    end else if (valid && wb_regwrite && (wb_rd == src)) begin
      r = {1'b0, SEL_WB};
    end
    return r;
  endfunction

  // Operand resolution, stall, flush and forward selects; all forced low during reset.
  always_comb begin
    infoA     = resolveOperand(id_rs);
    infoB     = resolveOperand(id_rt);
    needStall = infoA[2] | infoB[2];
    stall     = ~rst & needStall;
    if_flush  = ~rst & id_branch & id_taken & ~needStall;
    fwd_a     = SEL_RF;
    fwd_b     = SEL_RF;
    if (!rst && !needStall) begin
      fwd_a = infoA[1:0];
      fwd_b = infoB[1:0];
    end
    fwdEvent = id_branch & ~stall & ((fwd_a != SEL_RF) | (fwd_b != SEL_RF));
  end

  // Next-state for the saturating counters, the stall run length and the sticky watchdog.
  always_comb begin
    stallCnt_d = stallCnt_q;
    fwdCnt_d   = fwdCnt_q;
    runLen_d   = '0;
    if (stall && !(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (fwdEvent && !(&fwdCnt_q)) begin
      fwdCnt_d = fwdCnt_q + 1'b1;
    end
    if (stall) begin
      runLen_d = (runLen_q == MAX_RL) ? MAX_RL : runLen_q + 1'b1;
    end
    hazardErr_d = hazardErr_q | (stall & (runLen_d == MAX_RL));
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazardErr_q <= 1'b0;
      runLen_q    <= '0;
      stallCnt_q  <= '0;
      fwdCnt_q    <= '0;
    end else begin
      hazardErr_q <= hazardErr_d;
      runLen_q    <= runLen_d;
      stallCnt_q  <= stallCnt_d;
      fwdCnt_q    <= fwdCnt_d;
    end
  end

  assign hazard_err = hazardErr_q;
  assign stall_cnt  = stallCnt_q;
  assign fwd_cnt    = fwdCnt_q;

endmodule

// File: tb/tb_branch_fwd_hazard_unit.sv
// Directed bench for branch_fwd_hazard_unit.
// dut0 uses the default parameters (EX forwarding enabled, 16-bit counters).
// dut1 disables EX forwarding and uses 4-bit counters so saturation is reachable quickly.
module tb_branch_fwd_hazard_unit;

  logic       clock;
  logic       reset;
  logic       idBranch, idTaken;
  logic [4:0] idRs, idRt;
  logic       exRegwrite, exMemread;
  logic [4:0] exRd;
  logic       memRegwrite, memMemread;
  logic [4:0] memRd;
  logic       wbRegwrite;
  logic [4:0] wbRd;

  logic [1:0]  d0FwdA, d0FwdB;
  logic        d0Stall, d0Flush, d0Err;
  logic [15:0] d0StallCnt, d0FwdCnt;

  logic [1:0]  d1FwdA, d1FwdB;
  logic        d1Stall, d1Flush, d1Err;
  logic [3:0]  d1StallCnt, d1FwdCnt;

  int checkCount = 0;
  int errorCount = 0;

  branch_fwd_hazard_unit dut0 (
    .clk(clock), .rst(reset),
    .id_branch(idBranch), .id_taken(idTaken), .id_rs(idRs), .id_rt(idRt),
    .ex_regwrite(exRegwrite), .ex_memread(exMemread), .ex_rd(exRd),
    .mem_regwrite(memRegwrite), .mem_memread(memMemread), .mem_rd(memRd),
    .wb_regwrite(wbRegwrite), .wb_rd(wbRd),
    .fwd_a(d0FwdA), .fwd_b(d0FwdB), .stall(d0Stall), .if_flush(d0Flush),
    .hazard_err(d0Err), .stall_cnt(d0StallCnt), .fwd_cnt(d0FwdCnt)
  );

  branch_fwd_hazard_unit #(.AW(5), .CNT_W(4), .EX_FWD(0), .MAX_STALL(4)) dut1 (
    .clk(clock), .rst(reset),
    .id_branch(idBranch), .id_taken(idTaken), .id_rs(idRs), .id_rt(idRt),
    .ex_regwrite(exRegwrite), .ex_memread(exMemread), .ex_rd(exRd),
    .mem_regwrite(memRegwrite), .mem_memread(memMemread), .mem_rd(memRd),
    .wb_regwrite(wbRegwrite), .wb_rd(wbRd),
    .fwd_a(d1FwdA), .fwd_b(d1FwdB), .stall(d1Stall), .if_flush(d1Flush),
    .hazard_err(d1Err), .stall_cnt(d1StallCnt), .fwd_cnt(d1FwdCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic br, input logic taken, input logic [4:0] rs, input logic [4:0] rt,
    input logic exW, input logic exM, input logic [4:0] exD,
    input logic memW, input logic memM, input logic [4:0] memD,
    input logic wbW, input logic [4:0] wbD);
    idBranch    = br;
    idTaken     = taken;
    idRs        = rs;
    idRt        = rt;
    exRegwrite  = exW;
    exMemread   = exM;
    exRd        = exD;
    memRegwrite = memW;
    memMemread  = memM;
    memRd       = memD;
    wbRegwrite  = wbW;
    wbRd        = wbD;
    #1;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic advanceClock();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // Hazard plus taken branch presented while reset is held: everything must stay low.
    applyStimulus(1, 1, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst_stall", d0Stall, 0);
    checkOutput("rst_flush", d0Flush, 0);
    checkOutput("rst_fwdb", d0FwdB, 0);
    checkOutput("rst_err", d0Err, 0);
    checkOutput("rst_stallcnt", d0StallCnt, 0);
    checkOutput("rst_fwdcnt", d0FwdCnt, 0);
    advanceClock();
    reset = 1'b0;
    applyIdle();

    $display("[TB] test 1: ALU result in EX forwarded to rs");
    applyStimulus(1, 0, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0);
    checkOutput("t1_fwda", d0FwdA, 2'b01);
    checkOutput("t1_fwdb", d0FwdB, 2'b00);
    checkOutput("t1_stall", d0Stall, 0);
    checkOutput("t1_d1_stall", d1Stall, 1);
    advanceClock();
    checkOutput("t1_fwdcnt", d0FwdCnt, 1);

    $display("[TB] test 2: load in EX feeding rt");
    applyStimulus(1, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0);
    checkOutput("t2_stall_ex", d0Stall, 1);
    checkOutput("t2_fwdb_ex", d0FwdB, 2'b00);
    advanceClock();
    applyStimulus(1, 0, 0, 5, 0, 0, 0, 1, 1, 5, 0, 0);
    checkOutput("t2_stall_mem", d0Stall, 1);
    advanceClock();
    applyStimulus(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 5);
    checkOutput("t2_stall_wb", d0Stall, 0);
    checkOutput("t2_fwdb_wb", d0FwdB, 2'b11);
    checkOutput("t2_fwda_wb", d0FwdA, 2'b00);
    checkOutput("t2_stallcnt", d0StallCnt, 2);
    advanceClock();
    checkOutput("t2_fwdcnt", d0FwdCnt, 2);

    $display("[TB] test 3: all stages write the source register");
    applyStimulus(1, 0, 7, 7, 1, 0, 7, 1, 0, 7, 1, 7);
    checkOutput("t3_fwda", d0FwdA, 2'b01);
    checkOutput("t3_fwdb", d0FwdB, 2'b01);
    checkOutput("t3_stall", d0Stall, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0);
    checkOutput("t3_r0_fwda", d0FwdA, 2'b00);
    checkOutput("t3_r0_fwdb", d0FwdB, 2'b00);
    checkOutput("t3_r0_stall", d0Stall, 0);
    checkOutput("t3_r0_d1_stall", d1Stall, 0);
    applyIdle();
    advanceClock();

    $display("[TB] test 4: EX forwarding disabled, taken branch during stall");
    pulseReset();
    checkOutput("t4_d1_stallcnt0", d1StallCnt, 0);
    applyStimulus(1, 1, 9, 0, 1, 0, 9, 0, 0, 0, 0, 0);
    checkOutput("t4_d1_stall", d1Stall, 1);
    checkOutput("t4_d1_flush", d1Flush, 0);
    checkOutput("t4_d1_fwda", d1FwdA, 2'b00);
    checkOutput("t4_d0_fwda", d0FwdA, 2'b01);
    checkOutput("t4_d0_flush", d0Flush, 1);
    advanceClock();
    checkOutput("t4_d1_stallcnt", d1StallCnt, 1);
    applyStimulus(1, 1, 9, 0, 0, 0, 0, 1, 0, 9, 0, 0);
    checkOutput("t4_d1_stall2", d1Stall, 0);
    checkOutput("t4_d1_fwda2", d1FwdA, 2'b10);
    checkOutput("t4_d1_flush2", d1Flush, 1);
    advanceClock();
    checkOutput("t4_d1_fwdcnt", d1FwdCnt, 1);
    checkOutput("t4_d1_stallcnt2", d1StallCnt, 1);

    $display("[TB] test 5: watchdog on a held load-use hazard");
    applyIdle();
    advanceClock();
    pulseReset();
    applyStimulus(1, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0);
    repeat (3) advanceClock();
    checkOutput("t5_err_3", d0Err, 0);
    advanceClock();
    checkOutput("t5_err_4", d0Err, 1);
    checkOutput("t5_stallcnt", d0StallCnt, 4);
    applyIdle();
    advanceClock();
    checkOutput("t5_stall_clear", d0Stall, 0);
    checkOutput("t5_err_sticky", d0Err, 1);
    pulseReset();
    checkOutput("t5_err_rst", d0Err, 0);

    $display("[TB] test 6: counter saturation and asynchronous reset mid-stall");
    applyStimulus(1, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0);
    repeat (20) advanceClock();
    checkOutput("t6_d1_sat", d1StallCnt, 15);
    checkOutput("t6_d0_cnt", d0StallCnt, 20);
    checkOutput("t6_d1_err", d1Err, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_d0_stall", d0Stall, 0);
    checkOutput("t6_rst_d1_stall", d1Stall, 0);
    checkOutput("t6_rst_d0_cnt", d0StallCnt, 0);
    checkOutput("t6_rst_d1_cnt", d1StallCnt, 0);
    checkOutput("t6_rst_d0_fwdcnt", d0FwdCnt, 0);
    checkOutput("t6_rst_d0_err", d0Err, 0);
    reset = 1'b0;
    #1;
    checkOutput("t6_post_stall", d0Stall, 1);
    applyIdle();
    advanceClock();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
